fifo_write_arbiter: RTL and testbench

Round-robin arbiter sharing the single write port of one `fifo` instance among `NUM_REQ` independent producers. Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst, then rotates the grant. It sits directly upstream of the FIFO and drives its `write_i`/`write_data_i` from the granted producer, using `write_ready_o` as backpressure.

---
 rtl/fifo_write_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_write_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Optional FIFO_ARB_STATS_EN adds a 16-bit accepted-word counter on xfer_count_o.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic                         fifo_write_o,
    output logic [DATA_BITS-1:0]         fifo_write_data_o,
    input  logic                         fifo_write_ready_i,
    output logic [NUM_REQ-1:0]           grant_o
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]                  xfer_count_o
`endif
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CW-1:0]      burst_q, burst_d;

    logic               any_req;
    logic [IW-1:0]      win;
    logic               gvalid;
    logic               xfer;
    logic               rel;
    logic [CW-1:0]      burst_inc;

    // last_q doubles as the granted index: it is loaded with every new grant.
    always_comb begin
        win = last_q;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_valid_i[(int'(last_q) + i) % NUM_REQ])
                win = IW'((int'(last_q) + i) % NUM_REQ);
        end
    end

    assign any_req   = |req_valid_i;
    assign gvalid    = (state_q == GRANT) && req_valid_i[last_q];
    assign xfer      = gvalid && fifo_write_ready_i;
    assign burst_inc = burst_q + CW'(1);
    assign rel       = (state_q == GRANT) &&
                       (!gvalid || (xfer && (burst_inc == CW'(MAX_BURST))));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        burst_d = burst_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                    last_d  = win;
                    grant_d = NUM_REQ'(1) << win;
                    burst_d = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    burst_d = '0;
                    if (any_req) begin
                        last_d  = win;
                        grant_d = NUM_REQ'(1) << win;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (xfer) begin
                    burst_d = burst_inc;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                burst_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IW'(NUM_REQ - 1);
            grant_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
        end
    end

    // Datapath is steered only by the stored grant; no valid->ready path exists.
    always_comb begin
        fifo_write_o      = 1'b0;
        fifo_write_data_o = '0;
        req_ready_o       = '0;
        if (state_q == GRANT) begin
            fifo_write_o      = gvalid;
            fifo_write_data_o = req_data_i[int'(last_q)*DATA_BITS +: DATA_BITS];
            req_ready_o       = grant_q & {NUM_REQ{fifo_write_ready_i}};
        end
    end

    assign grant_o = grant_q;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] xfer_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            xfer_count_q <= '0;
        else if (xfer)
            xfer_count_q <= xfer_count_q + 16'd1;
    end

    assign xfer_count_o = xfer_count_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed table-driven bench for fifo_write_arbiter (NUM_REQ=4, MAX_BURST=4).
module tb_fifo_write_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_ready_o;
    logic        fifo_write_o;
    logic [7:0]  fifo_write_data_o;
    logic        fifo_write_ready_i;
    logic [3:0]  grant_o;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] xfer_count_o;
`endif

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .MAX_BURST(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid_i       (req_valid_i),
        .req_data_i        (req_data_i),
        .req_ready_o       (req_ready_o),
        .fifo_write_o      (fifo_write_o),
        .fifo_write_data_o (fifo_write_data_o),
        .fifo_write_ready_i(fifo_write_ready_i),
        .grant_o           (grant_o)
`ifdef FIFO_ARB_STATS_EN
        ,
        .xfer_count_o      (xfer_count_o)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] vld;
        logic       rdy;
        logic [3:0] gnt;
        logic [3:0] rr;
        logic       wr;
        logic [7:0] wd;
    } vec_t;

    vec_t vec [64];
    int   nvec;
    int   total;
    int   bad;

    task automatic add(input logic r, input logic [3:0] v, input logic y,
                       input logic [3:0] g, input logic [3:0] rr, input logic w,
                       input logic [7:0] d);
        vec[nvec].rst = r;
        vec[nvec].vld = v;
        vec[nvec].rdy = y;
        vec[nvec].gnt = g;
        vec[nvec].rr  = rr;
        vec[nvec].wr  = w;
        vec[nvec].wd  = d;
        nvec++;
    endtask

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
        end
    endtask

    // Reset is released one time unit after a rising edge, well away from the next.
    task automatic do_reset();
        reset              = 1'b1;
        req_valid_i        = '0;
        fifo_write_ready_i = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [7:0] pdata(input int k);
        return 8'h11 * 8'(k + 1);
    endfunction

    initial begin
        nvec  = 0;
        total = 0;
        bad   = 0;
        reset              = 1'b1;
        req_valid_i        = '0;
        fifo_write_ready_i = 1'b1;
        req_data_i         = {8'h44, 8'h33, 8'h22, 8'h11};

        // single producer 0: burst of 4, then regrant with no gap
        add(1, 4'b0001, 1, 4'b0000, 4'b0000, 0, 8'h00);
        for (int i = 0; i < 6; i++) add(0, 4'b0001, 1, 4'b0001, 4'b0001, 1, 8'h11);

        // all four requesting: 0,1,2,3,0 with 4 words each
        add(1, 4'b1111, 1, 4'b0000, 4'b0000, 0, 8'h00);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++)
                add(0, 4'b1111, 1, 4'(1 << k), 4'(1 << k), 1, pdata(k));
        add(0, 4'b1111, 1, 4'b0001, 4'b0001, 1, 8'h11);

        // producer 2 drops after 2 words, grant moves to 3
        add(1, 4'b1100, 1, 4'b0000, 4'b0000, 0, 8'h00);
        add(0, 4'b1100, 1, 4'b0100, 4'b0100, 1, 8'h33);
        add(0, 4'b1100, 1, 4'b0100, 4'b0100, 1, 8'h33);
        add(0, 4'b1000, 1, 4'b0100, 4'b0100, 0, 8'h33);
        add(0, 4'b1000, 1, 4'b1000, 4'b1000, 1, 8'h44);

        // producer 1 stalled 5 cycles mid-burst; burst still totals 4
        add(1, 4'b0010, 1, 4'b0000, 4'b0000, 0, 8'h00);
        add(0, 4'b0011, 1, 4'b0010, 4'b0010, 1, 8'h22);
        add(0, 4'b0011, 1, 4'b0010, 4'b0010, 1, 8'h22);
        for (int i = 0; i < 5; i++) add(0, 4'b0011, 0, 4'b0010, 4'b0000, 1, 8'h22);
        add(0, 4'b0011, 1, 4'b0010, 4'b0010, 1, 8'h22);
        add(0, 4'b0011, 1, 4'b0010, 4'b0010, 1, 8'h22);
        add(0, 4'b0011, 1, 4'b0001, 4'b0001, 1, 8'h11);

        for (int i = 0; i < nvec; i++) begin
            if (vec[i].rst) do_reset();
            req_valid_i        = vec[i].vld;
            fifo_write_ready_i = vec[i].rdy;
            #1;
            check("grant", i, 16'(grant_o), 16'(vec[i].gnt));
            check("req_ready", i, 16'(req_ready_o), 16'(vec[i].rr));
            check("fifo_write", i, 16'(fifo_write_o), 16'(vec[i].wr));
            check("write_data", i, 16'(fifo_write_data_o), 16'(vec[i].wd));
            @(posedge clock);
            #1;
        end

        // async reset mid-cycle during a grant
        do_reset();
        req_valid_i = 4'b0100;
        @(posedge clock);
        #1;
        check("async_pre_grant", 100, 16'(grant_o), 16'h0004);
        #2;
        reset = 1'b1;
        #1;
        check("async_grant", 101, 16'(grant_o), 16'h0000);
        check("async_write", 102, 16'(fifo_write_o), 16'h0000);
        check("async_ready", 103, 16'(req_ready_o), 16'h0000);
        #1;
        reset       = 1'b0;
        req_valid_i = 4'b1111;
        #1;
        check("async_idle", 104, 16'(grant_o), 16'h0000);
        @(posedge clock);
        #1;
        check("async_first_prio", 105, 16'(grant_o), 16'h0001);

`ifdef FIFO_ARB_STATS_EN
        do_reset();
        #1;
        check("stats_reset", 200, xfer_count_o, 16'h0000);
        req_valid_i = 4'b0001;
        for (int i = 0; i < 65538; i++) @(posedge clock);
        #1;
        check("stats_wrap", 201, xfer_count_o, 16'h0001);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
